instr_decode_stage: RTL
=======================

// Module: instr_decode_stage
// PURPOSE
//  Registered decode stage that produces the one-hot instruction flags consumed by the control signal generator.
//  - Accepts a fetched 32-bit MIPS word plus its PC through a valid/ready handshake.
//  - Classifies it as addu/subu/ori/lw/sw/beq/lui/jal/jr/nop/illegal.
//  - Holds flags, register fields and immediate in a one-entry output register with valid/ready, stall and flush.
//  - Sits between instruction memory/PC logic and the signal generator.
// PARAMETERS
//  CNT_W      16  width of accepted-instruction counter decode_count
//  ALLOW_NOP  1   1: word 32'h0000_0000 decodes as nop; 0: it decodes as illegal
// PORTS
//  clk           in   1      single clock, rising edge
//  reset         in   1      asynchronous, active-high reset
//  in_valid      in   1      instr/pc_in valid
//  in_ready      out  1      stage can accept this cycle
//  instr         in   32     fetched instruction word
//  pc_in         in   32     PC of instr
//  flush         in   1      discard held entry and any same-cycle input
//  out_valid     out  1      decoded entry held
//  out_ready     in   1      downstream consumes entry this cycle
//  addu,subu,ori,lw,sw,beq,lui,jal,jr  out 1 each  one-hot flags (0 when !out_valid)
//  nop           out  1      held word is nop
//  illegal       out  1      held word matches no supported encoding
//  rs,rt,rd      out  5 each instr[25:21],[20:16],[15:11] of held word
//  imm16         out  16     instr[15:0] of held word
//  instr_out     out  32     held word
//  pc_out        out  32     held PC
//  decode_count  out  CNT_W  number of accepted instructions
//  illegal_seen  out  1      sticky: an illegal word was ever accepted
// BEHAVIOUR
//  Reset (async, immediate):
//  - out_valid=0, all flags/nop/illegal=0.
//  - rs/rt/rd/imm16/instr_out/pc_out=0; decode_count=0; illegal_seen=0.
//  - Reset mid-transfer drops the held entry. No handshake completes during reset.
//  Handshake:
//  - in_ready = !flush && (!out_valid || out_ready).
//  - accept = in_valid && in_ready. Entry updates on the same clk edge; latency is 1 cycle.
//  - Full pipelining is supported: out_valid && out_ready && accept in one cycle replaces the entry, and out_valid stays 1.
//  - out_ready && !accept: out_valid -> 0.
//  - out_valid && !out_ready: entry, flags and fields hold stable (stall). in_ready=0.
//  Flush:
//  - Has priority over everything. Next edge gives out_valid=0 and flags=0.
//  - A same-cycle input is not accepted (in_ready=0). Counter and sticky are unchanged.
//  Decode (op=instr[31:26], fn=instr[5:0]):
//  - addu: op=000000, fn=100001
//  - subu: op=000000, fn=100011
//  - jr:   op=000000, fn=001000
//  - ori=001101, lw=100011, sw=101011, beq=000100, lui=001111, jal=000011
//  - nop: instr==0 when ALLOW_NOP=1. This takes precedence over op=0 R-type checks.
//  - Any other word: illegal=1, all instruction flags 0.
//  - Exactly one of {9 flags, nop, illegal} is 1 whenever out_valid=1; all are 0 when out_valid=0.
//  - Flags are registered, not decoded combinationally from instr_out.
//  Counter and sticky:
//  - decode_count += 1 on every accept (illegal included), modulo 2^CNT_W. Wraps silently.
//  - illegal_seen is set on accept of an illegal word. It is cleared only by reset.
//  Fields: rs/rt/rd/imm16 are sliced from the accepted word regardless of its type.
// TESTING
//  1. Reset, then in_valid=1, instr=32'h0232_4021 (addu $8,$17,$18), pc_in=32'h3000, out_ready=1
//     -> next cycle: out_valid=1, addu=1, rs=17, rt=18, rd=8, pc_out=32'h3000, decode_count=1.
//  2. Back-to-back ori 32'h3408_00FF, lw 32'h8D09_0004, jal 32'h0C00_0C00 with out_ready=1
//     -> one entry per cycle, flags ori, lw, jal in order; decode_count=3.
//  3. Hold out_ready=0 after sw 32'hAD09_0008
//     -> in_ready=0, sw=1 and imm16=16'h0008 stable for 5 cycles; raising out_ready accepts the next word the same cycle.
//  4. flush=1 while holding beq 32'h1109_FFFE and in_valid=1
//     -> next cycle out_valid=0, beq=0, decode_count unchanged, input not consumed.
//  5. instr=32'hFC00_0000 -> illegal=1, no other flags, illegal_seen=1 persists across later legal words.
//     instr=0 with ALLOW_NOP=1 -> nop=1; with ALLOW_NOP=0 -> illegal=1.
//  6. CNT_W=4: accept 17 words -> decode_count=1. Assert reset mid-stall
//     -> out_valid=0 and all outputs 0 immediately, before the next edge.

Source files
------------

// File: rtl/instr_decode_stage_if.sv
// ---------------------------------------------------------------------------
// instr_decode_stage_if
// Bundles the upstream handshake (fetch side) and the downstream decoded
// entry (signal generator side) of the decode stage.
//   Upstream   : in_valid, in_ready, instr[31:0], pc_in[31:0], flush
//   Downstream : out_valid, out_ready, one-hot flags (addu..jr, nop, illegal),
//                rs/rt/rd[4:0], imm16[15:0], instr_out/pc_out[31:0],
//                decode_count[CNT_W-1:0], illegal_seen
// Modports:
//   slave  - the decode stage's view
//   master - the view of whoever drives instructions and consumes entries
// ---------------------------------------------------------------------------
interface instr_decode_stage_if #(
  parameter int CNT_W = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      instr;
  logic [31:0]      pc_in;
  logic             flush;

  logic             out_valid;
  logic             out_ready;
  logic             addu;
  logic             subu;
  logic             ori;
  logic             lw;
  logic             sw;
  logic             beq;
  logic             lui;
  logic             jal;
  logic             jr;
  logic             nop;
  logic             illegal;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [15:0]      imm16;
  logic [31:0]      instr_out;
  logic [31:0]      pc_out;
  logic [CNT_W-1:0] decode_count;
  logic             illegal_seen;

  modport slave (
    input  in_valid, instr, pc_in, flush, out_ready,
    output in_ready, out_valid,
    output addu, subu, ori, lw, sw, beq, lui, jal, jr, nop, illegal,
    output rs, rt, rd, imm16, instr_out, pc_out, decode_count, illegal_seen
  );

  modport master (
    output in_valid, instr, pc_in, flush, out_ready,
    input  in_ready, out_valid,
    input  addu, subu, ori, lw, sw, beq, lui, jal, jr, nop, illegal,
    input  rs, rt, rd, imm16, instr_out, pc_out, decode_count, illegal_seen
  );

endinterface

// File: rtl/instr_decode_stage.sv
// ---------------------------------------------------------------------------
// instr_decode_stage
// Registered MIPS decode stage. A fetched word and its PC are taken in over
// a valid/ready handshake, classified into one-hot instruction flags, and
// held together with the register fields and immediate in a one-entry output
// register until the control signal generator consumes it.
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-high reset
//   bus    - instr_decode_stage_if.slave (handshakes, decoded entry,
//            accepted-instruction counter and sticky illegal flag)
// Parameters:
//   CNT_W     - width of decode_count (wraps modulo 2^CNT_W)
//   ALLOW_NOP - 1: the all-zero word decodes as nop; 0: it is illegal
// ---------------------------------------------------------------------------
module instr_decode_stage #(
  parameter int CNT_W     = 16,
  parameter bit ALLOW_NOP = 1'b1
) (
  input logic                clk,
  input logic                reset,
  instr_decode_stage_if.slave bus
);

  // Bit positions inside the one-hot flag vector.
  localparam int F_ADDU    = 0;
  localparam int F_SUBU    = 1;
  localparam int F_ORI     = 2;
  localparam int F_LW      = 3;
  localparam int F_SW      = 4;
  localparam int F_BEQ     = 5;
  localparam int F_LUI     = 6;
  localparam int F_JAL     = 7;
  localparam int F_JR      = 8;
  localparam int F_NOP     = 9;
  localparam int F_ILLEGAL = 10;
  localparam int NFLAGS    = 11;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic                r_outValid;
  logic [NFLAGS-1:0]   r_flags;
  logic [31:0]         r_instr;
  logic [31:0]         r_pc;
  logic [CNT_W-1:0]    r_decodeCount;
  logic                r_illegalSeen;

  logic                w_inReady;
  logic                w_accept;
  logic [5:0]          w_op;
  logic [5:0]          w_fn;
  logic                w_isNop;
  logic [NFLAGS-1:0]   w_decFlags;

  // The stage can take a word when it is empty or its entry leaves this
  // cycle; a flush blocks any same-cycle input so nothing slips past it.
  assign w_inReady = !bus.flush && (!r_outValid || bus.out_ready);
  assign w_accept  = bus.in_valid && w_inReady;

  assign w_op = bus.instr[31:26];
  assign w_fn = bus.instr[5:0];

  // The all-zero word would otherwise look like an R-type with a zero
  // function code, so it is recognised before the R-type table.
  assign w_isNop = ALLOW_NOP && (bus.instr == 32'h0000_0000);

  // Classify the incoming word; anything not in the table is illegal, which
  // guarantees exactly one bit of w_decFlags is set for every word.
  always_comb begin
    w_decFlags = '0;
    if (w_isNop) begin
      w_decFlags[F_NOP] = 1'b1;
    end else begin
      unique case (w_op)
        OP_RTYPE: begin
          unique case (w_fn)
            FN_ADDU: w_decFlags[F_ADDU]    = 1'b1;
            FN_SUBU: w_decFlags[F_SUBU]    = 1'b1;
            FN_JR:   w_decFlags[F_JR]      = 1'b1;
            default: w_decFlags[F_ILLEGAL] = 1'b1;
          endcase
        end
        OP_ORI:  w_decFlags[F_ORI]     = 1'b1;
        OP_LW:   w_decFlags[F_LW]      = 1'b1;
        OP_SW:   w_decFlags[F_SW]      = 1'b1;
        OP_BEQ:  w_decFlags[F_BEQ]     = 1'b1;
        OP_LUI:  w_decFlags[F_LUI]     = 1'b1;
        OP_JAL:  w_decFlags[F_JAL]     = 1'b1;
        default: w_decFlags[F_ILLEGAL] = 1'b1;
      endcase
    end
  end

  // Output entry register. Flush wins over everything, then a new word
  // replaces the entry (covers the full-throughput case where the old entry
  // leaves in the same cycle), then a consumed entry empties the stage.
  // Otherwise the entry holds (stall). Flags are cleared whenever the entry
  // is dropped so they read zero while out_valid is low; the word and PC
  // simply keep their last value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outValid    <= 1'b0;
      r_flags       <= '0;
      r_instr       <= '0;
      r_pc          <= '0;
      r_decodeCount <= '0;
      r_illegalSeen <= 1'b0;
    end else if (bus.flush) begin
      r_outValid <= 1'b0;
      r_flags    <= '0;
    end else if (w_accept) begin
      r_outValid    <= 1'b1;
      r_flags       <= w_decFlags;
      r_instr       <= bus.instr;
      r_pc          <= bus.pc_in;
      r_decodeCount <= r_decodeCount + 1'b1;
      if (w_decFlags[F_ILLEGAL]) begin
        r_illegalSeen <= 1'b1;
      end
    end else if (bus.out_ready) begin
      r_outValid <= 1'b0;
      r_flags    <= '0;
    end
  end

  assign bus.in_ready     = w_inReady;
  assign bus.out_valid    = r_outValid;

  assign bus.addu         = r_flags[F_ADDU];
  assign bus.subu         = r_flags[F_SUBU];
  assign bus.ori          = r_flags[F_ORI];
  assign bus.lw           = r_flags[F_LW];
  assign bus.sw           = r_flags[F_SW];
  assign bus.beq          = r_flags[F_BEQ];
  assign bus.lui          = r_flags[F_LUI];
  assign bus.jal          = r_flags[F_JAL];
  assign bus.jr           = r_flags[F_JR];
  assign bus.nop          = r_flags[F_NOP];
  assign bus.illegal      = r_flags[F_ILLEGAL];

  // Fields are sliced from the held word whatever its type; the signal
  // generator decides which of them are meaningful.
  assign bus.rs           = r_instr[25:21];
  assign bus.rt           = r_instr[20:16];
  assign bus.rd           = r_instr[15:11];
  assign bus.imm16        = r_instr[15:0];
  assign bus.instr_out    = r_instr;
  assign bus.pc_out       = r_pc;
  assign bus.decode_count = r_decodeCount;
  assign bus.illegal_seen = r_illegalSeen;

endmodule
